// File: rtl/approx_adder_err_sequencer.sv
// Self-test sequencer for a combinational approximate adder. Drives LFSR
// operand pairs into the adder, compares each registered result against the
// exact sum, and accumulates error count, maximum and summed error distance.
module approx_adder_err_sequencer #(
  parameter int              N           = 16,
  parameter int              NUM_SAMPLES = 1024,
  parameter logic [2*N-1:0]  SEED        = 32'hACE1_0001,
  parameter logic [2*N-1:0]  TAPS        = 32'h8020_0003,
  parameter int              CW          = $clog2(NUM_SAMPLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      op_x,
  output logic [N-1:0]      op_y,
  input  logic [N-1:0]      adder_s,
  input  logic              adder_co,
  output logic [CW-1:0]     err_count,
  output logic [N:0]        max_ed,
  output logic [N+CW:0]     sum_ed
);

  localparam int             SW       = N + 1 + CW;
  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [2*N-1:0] SEED_EFF = (SEED == '0) ? {{(2*N-1){1'b0}}, 1'b1} : SEED;
  localparam logic [CW-1:0]  NS_C     = CW'(NUM_SAMPLES);
  localparam logic [CW-1:0]  ONE_C    = CW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Fibonacci LFSR step: shift left, feedback is parity of tapped bits.
  function automatic logic [2*N-1:0] lfsr_next(input logic [2*N-1:0] l);
    return {l[2*N-2:0], ^(l & TAPS)};
  endfunction

  // Unsigned error distance |a - b|.
  function automatic logic [N:0] abs_diff(input logic [N:0] a, input logic [N:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [2*N-1:0]  lfsr_q, lfsr_d;
  logic [N-1:0]    op_x_q, op_x_d, op_y_q, op_y_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic [CW-1:0]   err_q, err_d;
  logic [N:0]      max_q, max_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [N:0]      exact, approx, ed;
  logic            acc, issue;

  // Error distance of the sample currently presented to the adder.
  always_comb begin
    exact  = {1'b0, op_x_q} + {1'b0, op_y_q};
    approx = {adder_co, adder_s};
    ed     = abs_diff(exact, approx);
  end

  // Next-state, issue and accumulate logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    op_x_d  = op_x_q;
    op_y_d  = op_y_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = err_q;
    max_d   = max_q;
    sum_d   = sum_q;
    acc     = 1'b0;
    issue   = 1'b0;
    cnt_inc = cnt_q + ONE_C;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = '0;
          max_d   = '0;
          sum_d   = '0;
          issue   = 1'b1;
          cnt_d   = ONE_C;
          valid_d = 1'b1;
          // The last sample's result lands in DRAIN, so a single-sample
          // run skips RUN entirely.
          state_d = (NS_C == ONE_C) ? DRAIN : RUN;
        end
      end
      RUN: begin
        acc = valid_q;
        if (cnt_q < NS_C) begin
          issue = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == NS_C) state_d = DRAIN;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        acc     = valid_q;
        valid_d = 1'b0;
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      op_x_d = lfsr_q[2*N-1:N];
      op_y_d = lfsr_q[N-1:0];
      lfsr_d = lfsr_next(lfsr_q);
    end
    if (acc) begin
      err_d = err_q + CW'(ed != '0);
      max_d = (ed > max_q) ? ed : max_q;
      sum_d = sum_q + SW'(ed);
    end
  end

  // State and datapath registers; reset abandons any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= SEED_EFF;
      op_x_q  <= '0;
      op_y_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      max_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      op_x_q  <= op_x_d;
      op_y_q  <= op_y_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign op_x      = op_x_q;
  assign op_y      = op_y_q;
  assign err_count = err_q;
  assign max_ed    = max_q;
  assign sum_ed    = sum_q;

endmodule

// File: tb/tb_approx_adder_err_sequencer.sv
// Scoreboard bench for approx_adder_err_sequencer: four instances with
// different adder stubs and sample counts; expectations are queued at
// stimulus time and popped by per-instance monitors on busy/done.
module tb_approx_adder_err_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] e;
    logic [31:0] m;
    logic [31:0] s;
  } stat_t;

  stat_t       qs_a[$], qs_b[$], qs_c[$], qs_d[$];
  logic [31:0] qv_a[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_stat(input string nm, input stat_t ex,
                          input logic [31:0] e, input logic [31:0] m, input logic [31:0] s);
    chk({nm, "_err_count"}, e, ex.e);
    chk({nm, "_max_ed"},    m, ex.m);
    chk({nm, "_sum_ed"},    s, ex.s);
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], ^(l & 32'h8020_0003)};
  endfunction

  // HOERAA-style adder, N=16, K=10: exact upper part with carry-in from the
  // MSB of the lower part, OR-based lower part.
  function automatic logic [16:0] hoeraa(input logic [15:0] a, input logic [15:0] b);
    logic [6:0] hi;
    logic [9:0] lo;
    logic       c;
    c        = a[9] & b[9];
    hi       = {1'b0, a[15:10]} + {1'b0, b[15:10]} + {6'd0, c};
    lo[9]    = (a[9] ^ b[9]) | (a[8] & b[8]);
    lo[8:0]  = (a[8:0] | b[8:0]) | {9{c}};
    return {hi, lo};
  endfunction

  // ---------------- instance A: exact adder, 4 samples ----------------
  logic rst_n_a, start_a, busy_a, done_a, co_a;
  logic [15:0] op_x_a, op_y_a, s_a;
  logic [2:0]  err_a;
  logic [16:0] max_a;
  logic [19:0] sum_a;
  assign {co_a, s_a} = {1'b0, op_x_a} + {1'b0, op_y_a};

  approx_adder_err_sequencer #(.N(16), .NUM_SAMPLES(4)) u_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .busy(busy_a), .done(done_a),
    .op_x(op_x_a), .op_y(op_y_a), .adder_s(s_a), .adder_co(co_a),
    .err_count(err_a), .max_ed(max_a), .sum_ed(sum_a));

  // ---------------- instance B: exact+1 adder, 4 samples ----------------
  logic rst_n, start_b, busy_b, done_b, co_b;
  logic [15:0] op_x_b, op_y_b, s_b;
  logic [2:0]  err_b;
  logic [16:0] max_b;
  logic [19:0] sum_b;
  assign {co_b, s_b} = {1'b0, op_x_b} + {1'b0, op_y_b} + 17'd1;

  approx_adder_err_sequencer #(.N(16), .NUM_SAMPLES(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .op_x(op_x_b), .op_y(op_y_b), .adder_s(s_b), .adder_co(co_b),
    .err_count(err_b), .max_ed(max_b), .sum_ed(sum_b));

  // ---------------- instance C: HOERAA, 1024 samples ----------------
  logic start_c, busy_c, done_c, co_c;
  logic [15:0] op_x_c, op_y_c, s_c;
  logic [10:0] err_c;
  logic [16:0] max_c;
  logic [27:0] sum_c;
  assign {co_c, s_c} = hoeraa(op_x_c, op_y_c);

  approx_adder_err_sequencer #(.N(16), .NUM_SAMPLES(1024)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c),
    .op_x(op_x_c), .op_y(op_y_c), .adder_s(s_c), .adder_co(co_c),
    .err_count(err_c), .max_ed(max_c), .sum_ed(sum_c));

  // ---------------- instance D: zero adder, 1 sample, all-ones seed ----------------
  logic start_d, busy_d, done_d, co_d;
  logic [15:0] op_x_d, op_y_d, s_d;
  logic [0:0]  err_d;
  logic [16:0] max_d;
  logic [17:0] sum_d;
  assign {co_d, s_d} = 17'd0;

  approx_adder_err_sequencer #(.N(16), .NUM_SAMPLES(1), .SEED(32'hFFFF_FFFF)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .busy(busy_d), .done(done_d),
    .op_x(op_x_d), .op_y(op_y_d), .adder_s(s_d), .adder_co(co_d),
    .err_count(err_d), .max_ed(max_d), .sum_ed(sum_d));

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (busy_a) begin
      chk("a_vec_pending", 32'(qv_a.size() > 0), 32'd1);
      if (qv_a.size() > 0) chk("a_operands", {op_x_a, op_y_a}, qv_a.pop_front());
    end
    if (done_a) begin
      chk("a_done_pending", 32'(qs_a.size() > 0), 32'd1);
      if (qs_a.size() > 0) cmp_stat("a", qs_a.pop_front(), 32'(err_a), 32'(max_a), 32'(sum_a));
    end
  end

  always @(negedge clk) begin
    if (done_b) begin
      chk("b_done_pending", 32'(qs_b.size() > 0), 32'd1);
      if (qs_b.size() > 0) cmp_stat("b", qs_b.pop_front(), 32'(err_b), 32'(max_b), 32'(sum_b));
    end
  end

  always @(negedge clk) begin
    if (done_c) begin
      chk("c_done_pending", 32'(qs_c.size() > 0), 32'd1);
      if (qs_c.size() > 0) cmp_stat("c", qs_c.pop_front(), 32'(err_c), 32'(max_c), 32'(sum_c));
    end
  end

  always @(negedge clk) begin
    if (done_d) begin
      chk("d_done_pending", 32'(qs_d.size() > 0), 32'd1);
      if (qs_d.size() > 0) cmp_stat("d", qs_d.pop_front(), 32'(err_d), 32'(max_d), 32'(sum_d));
    end
  end

  // ---------------- stimulus ----------------
  // First eight operand pairs {op_x, op_y} from SEED, worked by hand.
  logic [31:0] hv [8] = '{32'hACE1_0001, 32'h59C2_0003, 32'hB384_0006, 32'h6708_000C,
                          32'hCE10_0018, 32'h9C20_0031, 32'h3840_0063, 32'h7080_00C6};
  logic [31:0] lfsr_a_m;
  logic [31:0] lfsr_c_m;
  stat_t       zero_st = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model_a(input int n);
    for (int i = 0; i < n; i++) begin
      qv_a.push_back(lfsr_a_m);
      lfsr_a_m = lfsr_step(lfsr_a_m);
    end
  endtask

  // Pulse start on A and check busy/done framing; optionally re-pulse start
  // in cycles 2 and 3 of the run.
  task automatic run_a(input bit repulse);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("a_busy_in_run", 32'(busy_a), 32'd1);
      chk("a_done_in_run", 32'(done_a), 32'd0);
      start_a = repulse && (k == 1 || k == 2);
      tick();
    end
    start_a = 1'b0;
    chk("a_done_pulse", 32'(done_a), 32'd1);
    chk("a_busy_at_done", 32'(busy_a), 32'd0);
    tick();
    chk("a_done_cleared", 32'(done_a), 32'd0);
    chk("a_busy_after", 32'(busy_a), 32'd0);
  endtask

  task automatic gold_c();
    stat_t       st;
    logic [15:0] x, y;
    logic [16:0] ex, ap, ed;
    st = '0;
    for (int i = 0; i < 1024; i++) begin
      x  = lfsr_c_m[31:16];
      y  = lfsr_c_m[15:0];
      ex = {1'b0, x} + {1'b0, y};
      ap = hoeraa(x, y);
      ed = (ex >= ap) ? ex - ap : ap - ex;
      if (ed != 17'd0) st.e = st.e + 32'd1;
      if (32'(ed) > st.m) st.m = 32'(ed);
      st.s = st.s + 32'(ed);
      lfsr_c_m = lfsr_step(lfsr_c_m);
    end
    qs_c.push_back(st);
  endtask

  task automatic wait_done_c(input string nm);
    int n;
    n = 0;
    while (!done_c && n < 1100) begin
      tick();
      n++;
    end
    chk(nm, 32'(n), 32'd1024);
    tick();
  endtask

  initial begin
    logic [31:0] first_c;
    rst_n = 1'b0; rst_n_a = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    #3;
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_ops_a", {op_x_a, op_y_a}, 32'd0);
    chk("rst_stats_a", {9'd0, err_a, max_a, 3'd0} | 32'(sum_a), 32'd0);
    chk("rst_ops_d", {op_x_d, op_y_d}, 32'd0);
    #20;
    rst_n = 1'b1; rst_n_a = 1'b1;
    tick();

    // A: basic run with hand vectors.
    for (int i = 0; i < 4; i++) qv_a.push_back(hv[i]);
    qs_a.push_back(zero_st);
    run_a(1'b0);

    // A: start held high -> back-to-back runs, LFSR continues.
    for (int i = 4; i < 8; i++) qv_a.push_back(hv[i]);
    qs_a.push_back(zero_st);
    lfsr_a_m = lfsr_step(32'h7080_00C6);
    push_model_a(4);
    qs_a.push_back(zero_st);
    start_a = 1'b1;
    tick();
    repeat (4) tick();
    chk("a_held_done1", 32'(done_a), 32'd1);
    chk("a_held_busy_at_done", 32'(busy_a), 32'd0);
    tick();
    chk("a_held_restart_busy", 32'(busy_a), 32'd1);
    chk("a_held_restart_done", 32'(done_a), 32'd0);
    start_a = 1'b0;
    repeat (4) tick();
    chk("a_held_done2", 32'(done_a), 32'd1);
    tick();
    chk("a_held_idle", 32'(busy_a), 32'd0);

    // A: start re-pulsed mid-run is ignored.
    push_model_a(4);
    qs_a.push_back(zero_st);
    run_a(1'b1);

    // A: async reset at cycle 2 of a run.
    push_model_a(2);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    #1;
    rst_n_a = 1'b0;
    #1;
    chk("a_arst_busy", 32'(busy_a), 32'd0);
    chk("a_arst_done", 32'(done_a), 32'd0);
    chk("a_arst_ops", {op_x_a, op_y_a}, 32'd0);
    chk("a_arst_err", 32'(err_a), 32'd0);
    chk("a_arst_sum", 32'(sum_a), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("a_arst_no_done", 32'(done_a), 32'd0);
    end
    #2;
    rst_n_a = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) qv_a.push_back(hv[i]);
    qs_a.push_back(zero_st);
    run_a(1'b0);

    // B: every sample off by one.
    qs_b.push_back('{e: 32'd4, m: 32'd1, s: 32'd4});
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (4) tick();
    chk("b_done_latency", 32'(done_b), 32'd1);
    tick();

    // D: single sample, 0xFFFF + 0xFFFF against a zero adder.
    qs_d.push_back('{e: 32'd1, m: 32'h1FFFE, s: 32'h1FFFE});
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    chk("d_busy", 32'(busy_d), 32'd1);
    chk("d_done_early", 32'(done_d), 32'd0);
    chk("d_ops", {op_x_d, op_y_d}, 32'hFFFF_FFFF);
    tick();
    chk("d_done_latency", 32'(done_d), 32'd1);
    chk("d_busy_at_done", 32'(busy_d), 32'd0);
    tick();

    // C: HOERAA over two consecutive runs.
    lfsr_c_m = 32'hACE1_0001;
    gold_c();
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    chk("c_first_op_run1", {op_x_c, op_y_c}, 32'hACE1_0001);
    wait_done_c("c_latency_run1");
    first_c = lfsr_c_m;
    gold_c();
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    chk("c_first_op_run2", {op_x_c, op_y_c}, first_c);
    wait_done_c("c_latency_run2");

    repeat (2) tick();
    chk("a_vec_left", 32'(qv_a.size()), 32'd0);
    chk("a_stats_left", 32'(qs_a.size()), 32'd0);
    chk("b_stats_left", 32'(qs_b.size()), 32'd0);
    chk("c_stats_left", 32'(qs_c.size()), 32'd0);
    chk("d_stats_left", 32'(qs_d.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
